// File: rtl/ila_capture_ctrl_if.sv
// FIFO and readout bundle for the ILA capture sequencer.
// master = sequencer side, slave = FIFO/readout side.
interface ila_capture_ctrl_if #(
  parameter int DATA_W = 20
);
  logic              FIFO_RST_N;
  logic              FIFO_PUSH;
  logic [DATA_W-1:0] FIFO_DI;
  logic              FIFO_POP;
  logic [DATA_W-1:0] FIFO_DO;
  logic              FIFO_FULL;
  logic              RD_VALID;
  logic              RD_READY;
  logic [DATA_W-1:0] RD_DATA;

  modport master (
    output FIFO_RST_N,
    output FIFO_PUSH,
    output FIFO_DI,
    output FIFO_POP,
    input  FIFO_DO,
    input  FIFO_FULL,
    output RD_VALID,
    output RD_DATA,
    input  RD_READY
  );

  modport slave (
    input  FIFO_RST_N,
    input  FIFO_PUSH,
    input  FIFO_DI,
    input  FIFO_POP,
    output FIFO_DO,
    output FIFO_FULL,
    input  RD_VALID,
    input  RD_DATA,
    output RD_READY
  );
endinterface

// File: rtl/ila_capture_ctrl.sv
// ILA capture sequencer: pre-trigger window, post-trigger fill, readout.
// Ports: CLK/RST_N, ARM/ABORT/TRIG/SAMPLE_IN, bus (FIFO + readout,
// master), BUSY/DONE/TRIG_IDX/OVF_ERR. Option: ILA_SAMPLE_QUAL_EN.
module ila_capture_ctrl #(
  parameter int DATA_W    = 20,
  parameter int DEPTH     = 2048,
  parameter int PRE_DEPTH = 512,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ARM,
  input  logic              ABORT,
  input  logic              TRIG,
  input  logic [DATA_W-1:0] SAMPLE_IN,
`ifdef ILA_SAMPLE_QUAL_EN
  input  logic              SAMPLE_QUAL,
`endif
  ila_capture_ctrl_if.master bus,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  TRIG_IDX,
  output logic              OVF_ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_C = CNT_W'(PRE_DEPTH);
  localparam logic [CNT_W-1:0] POST_C = CNT_W'(DEPTH - 1 - PRE_DEPTH);
  localparam logic [CNT_W-1:0] REM_C = CNT_W'(DEPTH - 1);

  logic [2:0]       state_q, state_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] trig_idx_q, trig_idx_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             fifo_rst_n_q, fifo_rst_n_d;
  logic             push, pop, qual;
  logic [CNT_W-1:0] fill_inc, post_inc;

`ifdef ILA_SAMPLE_QUAL_EN
  assign qual = SAMPLE_QUAL;
`else
  assign qual = 1'b1;
`endif

  assign fill_inc = fill_q + ONE;
  assign post_inc = post_q + ONE;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    fill_d     = fill_q;
    post_d     = post_q;
    remain_d   = remain_q;
    trig_idx_d = trig_idx_q;
    rd_valid_d = rd_valid_q;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ARM) begin
          state_d = S_FLUSH;
          flush_d = 1'b0;
        end
      end
      S_FLUSH: begin
        fill_d     = '0;
        post_d     = '0;
        remain_d   = '0;
        trig_idx_d = '0;
        if (flush_q) state_d = S_PRE;
        else         flush_d = 1'b1;
      end
      S_PRE: begin
        if (qual) begin
          push   = 1'b1;
          fill_d = fill_inc;
          if (fill_inc == PRE_C) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (qual) begin
          push = 1'b1;
          if (TRIG) begin
            fill_d     = fill_inc;
            post_d     = ONE;
            trig_idx_d = PRE_C;
            // window may leave room for the trigger sample only
            if (POST_C == ONE) begin
              state_d  = S_READ;
              remain_d = REM_C;
            end else begin
              state_d = S_POST;
            end
          end else begin
            pop = 1'b1;
          end
        end
      end
      S_POST: begin
        if (qual) begin
          push   = 1'b1;
          fill_d = fill_inc;
          post_d = post_inc;
          if (post_inc == POST_C) begin
            state_d  = S_READ;
            remain_d = REM_C;
          end
        end
      end
      S_READ: begin
        // refill the output register whenever it is empty or draining
        pop = (!rd_valid_q || bus.RD_READY) && (remain_q != '0);
        if (pop) begin
          remain_d   = remain_q - ONE;
          rd_valid_d = 1'b1;
        end else if (bus.RD_READY) begin
          rd_valid_d = 1'b0;
          if (rd_valid_q && remain_q == '0) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ABORT) begin
      state_d    = S_IDLE;
      push       = 1'b0;
      pop        = 1'b0;
      rd_valid_d = 1'b0;
    end
  end

  assign fifo_rst_n_d = !ABORT && (state_d != S_FLUSH);
  assign ovf_d = ovf_q | (push & bus.FIFO_FULL);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      flush_q      <= 1'b0;
      fill_q       <= '0;
      post_q       <= '0;
      remain_q     <= '0;
      trig_idx_q   <= '0;
      rd_valid_q   <= 1'b0;
      ovf_q        <= 1'b0;
      fifo_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      fill_q       <= fill_d;
      post_q       <= post_d;
      remain_q     <= remain_d;
      trig_idx_q   <= trig_idx_d;
      rd_valid_q   <= rd_valid_d;
      ovf_q        <= ovf_d;
      fifo_rst_n_q <= fifo_rst_n_d;
    end
  end

  assign bus.FIFO_RST_N = fifo_rst_n_q;
  assign bus.FIFO_PUSH  = push;
  assign bus.FIFO_DI    = push ? SAMPLE_IN : '0;
  assign bus.FIFO_POP   = pop;
  assign bus.RD_VALID   = rd_valid_q;
  assign bus.RD_DATA    = rd_valid_q ? bus.FIFO_DO : '0;

  assign BUSY     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign DONE     = (state_q == S_DONE);
  assign TRIG_IDX = trig_idx_q;
  assign OVF_ERR  = ovf_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl, DEPTH=16 / PRE_DEPTH=4,
// with a behavioural FIFO on the slave side of the bus.
module tb_ila_capture_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ARM = 1'b0;
  logic        ABORT = 1'b0;
  logic        TRIG = 1'b0;
  logic [19:0] SAMPLE_IN = '0;
  logic        BUSY, DONE, OVF_ERR;
  logic [15:0] TRIG_IDX;
  logic        rdy = 1'b0;
  logic        full_force = 1'b0;
  logic        full_r = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  ila_capture_ctrl_if #(.DATA_W(20)) bus ();

  ila_capture_ctrl #(
    .DATA_W(20), .DEPTH(16), .PRE_DEPTH(4), .CNT_W(16)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ARM      (ARM),
    .ABORT    (ABORT),
    .TRIG     (TRIG),
    .SAMPLE_IN(SAMPLE_IN),
`ifdef ILA_SAMPLE_QUAL_EN
    .SAMPLE_QUAL(1'b1),
`endif
    .bus      (bus.master),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .TRIG_IDX (TRIG_IDX),
    .OVF_ERR  (OVF_ERR)
  );

  logic [19:0] fq[$];
  logic [19:0] fdo = '0;
  logic        s_push = 1'b0;
  logic        s_pop = 1'b0;
  logic        s_rst = 1'b0;
  logic [19:0] s_di = '0;

  assign bus.FIFO_DO   = fdo;
  assign bus.FIFO_FULL = full_r;
  assign bus.RD_READY  = rdy;

  always @(negedge CLK) begin
    s_push = bus.FIFO_PUSH;
    s_pop  = bus.FIFO_POP;
    s_rst  = bus.FIFO_RST_N;
    s_di   = bus.FIFO_DI;
    full_r = full_force || (fq.size() >= 16);
  end

  always @(posedge CLK) begin
    if (!s_rst) begin
      fq.delete();
      fdo <= '0;
    end else begin
      if (s_pop && fq.size() > 0) fdo <= fq.pop_front();
      if (s_push) fq.push_back(s_di);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: full run, 1: abort in POST, 2: reset in readout
  task automatic capture(input bit trig_hold, input int trig_at,
                         input int mode, input bit rdy_tog);
    int smp, ro_at, n, nv, first_v, last_v, exp_trig;
    bit pv, pr, done_seen;
    logic [19:0] pd;
    exp_trig = trig_hold ? 6 : trig_at;
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    smp = 0;
    SAMPLE_IN = 20'd0;
    TRIG = trig_hold;
    #1;
    chk("flush0_rstn", bus.FIFO_RST_N, 0);
    chk("flush0_busy", BUSY, 1);
    ro_at = -1;
    for (int c = 0; c < 200 && ro_at < 0; c++) begin
      tick();
      smp++;
      SAMPLE_IN = 20'(smp);
      if (!trig_hold) TRIG = (smp == trig_at);
      full_force = (mode == 2 && smp == 3);
      #1;
      if (smp == 1) chk("flush1_rstn", bus.FIFO_RST_N, 0);
      if (smp == 2) begin
        chk("pre_rstn", bus.FIFO_RST_N, 1);
        chk("pre_push", bus.FIFO_PUSH, 1);
        chk("pre_di", bus.FIFO_DI, 2);
      end
      if (mode == 1 && smp == 25) begin
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        TRIG = 1'b0;
        #1;
        chk("abort_busy", BUSY, 0);
        chk("abort_rstn", bus.FIFO_RST_N, 0);
        chk("abort_push", bus.FIFO_PUSH, 0);
        tick();
        chk("abort_rstn_rel", bus.FIFO_RST_N, 1);
        return;
      end
      if (BUSY && bus.FIFO_RST_N && !bus.FIFO_PUSH) ro_at = smp;
    end
    TRIG = 1'b0;
    chk("ro_entry", ro_at, exp_trig + 11);
    chk("ro_fill", fq.size(), 15);
    chk("trig_idx", TRIG_IDX, 4);
    chk("ovf", OVF_ERR, (mode == 2) ? 1 : 0);
    n = 0; nv = 0; first_v = -1; last_v = -1;
    pv = 0; pr = 0; pd = '0; done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) tick();
      rdy = rdy_tog ? (c % 2 == 1) : 1'b1;
      #1;
      if (DONE) begin
        done_seen = 1;
        break;
      end
      if (mode == 2 && n == 5) begin
        RST_N = 1'b0;
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_valid", bus.RD_VALID, 0);
        chk("rst_data", bus.RD_DATA, 0);
        chk("rst_pop", bus.FIFO_POP, 0);
        chk("rst_push", bus.FIFO_PUSH, 0);
        chk("rst_fifo_rstn", bus.FIFO_RST_N, 0);
        chk("rst_tidx", TRIG_IDX, 0);
        chk("rst_ovf", OVF_ERR, 0);
        rdy = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        chk("rel_busy", BUSY, 0);
        chk("rel_rstn", bus.FIFO_RST_N, 1);
        return;
      end
      if (pv && !pr) begin
        chk("hold_valid", bus.RD_VALID, 1);
        chk("hold_data", bus.RD_DATA, pd);
      end
      if (bus.RD_VALID) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (bus.RD_VALID && rdy) begin
        chk("word", bus.RD_DATA, exp_trig - 4 + n);
        n++;
      end
      pv = bus.RD_VALID;
      pr = rdy;
      pd = bus.RD_DATA;
    end
    chk("done_seen", done_seen, 1);
    chk("word_count", n, 15);
    if (!rdy_tog) begin
      chk("valid_cycles", nv, 15);
      chk("valid_span", last_v - first_v + 1, 15);
    end
    chk("done_busy", BUSY, 0);
    chk("done_valid", bus.RD_VALID, 0);
    chk("done_tidx", TRIG_IDX, 4);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_rstn", bus.FIFO_RST_N, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_valid", bus.RD_VALID, 0);
    chk("reset_tidx", TRIG_IDX, 0);
    RST_N = 1'b1;
    tick();
    chk("idle_rstn", bus.FIFO_RST_N, 1);
    chk("idle_busy", BUSY, 0);

    capture(1'b0, 20, 0, 1'b0);
    repeat (2) tick();
    chk("done_hold", DONE, 1);

    capture(1'b1, 0, 0, 1'b0);
    capture(1'b0, 20, 0, 1'b1);

    capture(1'b0, 20, 1, 1'b0);
    capture(1'b0, 20, 0, 1'b0);

    capture(1'b0, 20, 2, 1'b0);
    capture(1'b0, 20, 0, 1'b0);
    chk("post_rst_ovf", OVF_ERR, 0);

    ARM = 1'b1;
    ABORT = 1'b1;
    tick();
    ARM = 1'b0;
    ABORT = 1'b0;
    chk("armabort_busy", BUSY, 0);
    chk("armabort_done", DONE, 0);
    chk("armabort_rstn", bus.FIFO_RST_N, 0);
    tick();
    chk("armabort_rel", bus.FIFO_RST_N, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
